vry_bottle_sense: RTL and testbench
===================================

// Module: vry_bottle_sense
// PURPOSE
//  Upstream qualifier for vry_BottlePrint: turns the raw photo-eye bottle sensor into the clean
//  one-cycle valid_edge_f1 strobe the print stage consumes. Synchronises and debounces the sensor,
//  then enforces a minimum bottle-to-bottle gap. Keeps a bottle counter and flags rejected edges.
// PARAMETERS
//  SYNC_STAGES  2    synchroniser flops on sensor_in (>=2)
//  DEB_CYC      16   cycles a level must be stable to be accepted (1..65535)
//  MIN_GAP      1000 min cycles between accepted valid_edge_f1 pulses (1..65535)
//  CNT_W        16   width of bottle_cnt
// PORTS
//  clk_100        in   1      system clock, 100 MHz
//  nRST           in   1      reset, synchronous, active-low
//  sensor_in      in   1      raw photo-eye, async, 1 = bottle present
//  sense_en       in   1      1 = accepted edges issue valid_edge_f1
//  b_p_clr        in   1      sync clear of bottle_cnt and gap_err_flag
//  valid_edge_f1  out  1      1-cycle strobe per accepted bottle leading edge
//  bottle_present out  1      debounced presence level
//  bottle_cnt     out  CNT_W  accepted-bottle count, wraps at 2^CNT_W
//  gap_err        out  1      1-cycle strobe: qualified edge rejected by MIN_GAP
//  gap_err_flag   out  1      sticky copy of gap_err, cleared by b_p_clr
//  b_len          out  16     last accepted bottle length in cycles (see CONFIGURATION)
//  b_len_vld      out  1      1-cycle strobe when b_len updates
// BEHAVIOUR
//  - Reset (nRST=0 at clk_100 edge): all outputs 0, FSM=EMPTY, debounce cnt 0, gap cnt=MIN_GAP
//    (first bottle always accepted), sync chain 0. Reset mid-bottle abandons it; no pulse issued.
//  - s = last sync stage. FSM (debounce cnt dc, 16 bit):
//    EMPTY:   s=1 -> RISE, dc=1.
//    RISE:    s=0 -> EMPTY; s=1 & dc=DEB_CYC-1 -> PRESENT (accept point); else dc++.
//    PRESENT: s=0 -> FALL, dc=1.
//    FALL:    s=1 -> PRESENT; s=0 & dc=DEB_CYC-1 -> EMPTY; else dc++.
//    DEB_CYC=1: RISE/FALL resolve in one cycle.
//  - bottle_present=1 in PRESENT and FALL.
//  - Accept point: if gap cnt>=MIN_GAP and sense_en=1 -> valid_edge_f1=1 next cycle, bottle_cnt++,
//    gap cnt cleared to 0. If gap cnt<MIN_GAP -> gap_err=1, gap_err_flag set, no strobe,
//    no count, gap cnt unchanged. If sense_en=0 -> silent, nothing changes.
//  - Latency: sensor_in rise to valid_edge_f1 high = SYNC_STAGES+DEB_CYC cycles.
//  - gap cnt increments every cycle, saturating at MIN_GAP; independent of sense_en.
//  - sense_en rising while in PRESENT/FALL: no strobe for that bottle (edge already past).
//  - b_p_clr same cycle as an accept: bottle_cnt=1 afterwards (clear, then count); gap_err in
//    same cycle: gap_err_flag=1 (set wins). b_p_clr never touches FSM or gap cnt.
//  - valid_edge_f1 never asserted on two consecutive cycles; a glitch < DEB_CYC never counted.
// CONFIGURATION
//  BS_LEN_MEAS_EN defined: 16-bit len cnt cleared on EMPTY->RISE, +1 every cycle s=1 in
//    RISE/PRESENT/FALL, saturating at 16'hFFFF. On FALL->EMPTY for a bottle that issued
//    valid_edge_f1, b_len<=len cnt and b_len_vld=1 for one cycle. Clean N-cycle pulse -> b_len=N.
//    Rejected/silent bottles: no update.
//  BS_LEN_MEAS_EN undefined: counter not built; b_len=0 and b_len_vld=0 constantly.
// TESTING  (SYNC_STAGES=2, DEB_CYC=4, MIN_GAP=50, BS_LEN_MEAS_EN defined)
//  1 nRST low 10 cycles with sensor_in toggling -> all outputs 0; nRST high, sensor_in=0 -> none rise.
//  2 sensor_in high 20 cycles -> valid_edge_f1 1 cycle, 6 cycles after rise; bottle_cnt=1;
//    bottle_present high 20 cycles; b_len=20 with b_len_vld 1 cycle.
//  3 sensor_in high 3 cycles, then 1/0 chatter of 2 cycles -> no strobe, bottle_cnt unchanged.
//  4 two 10-cycle bottles, rises 30 cycles apart -> first strobed, second gap_err pulse,
//    gap_err_flag=1, bottle_cnt=1; third bottle 60 cycles after first -> strobed, cnt=2.
//  5 sense_en=0 over a bottle rise, re-raise mid-bottle -> no strobe, cnt unchanged; next bottle
//    strobed normally.
//  6 b_p_clr asserted on the accept cycle with bottle_cnt=7 -> bottle_cnt=1; b_p_clr alone -> 0,
//    gap_err_flag cleared.

Source files
------------

// File: rtl/vry_bottle_sense.sv
// Photo-eye qualifier: sync + debounce + minimum-gap gating producing valid_edge_f1.
// Optional bottle length measurement when BS_LEN_MEAS_EN is defined.
module vry_bottle_sense #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYC     = 16,
   parameter int MIN_GAP     = 1000,
   parameter int CNT_W       = 16
) (
   input  logic             clk_100,
   input  logic             nRST,
   input  logic             sensor_in,
   input  logic             sense_en,
   input  logic             b_p_clr,
   output logic             valid_edge_f1,
   output logic             bottle_present,
   output logic [CNT_W-1:0] bottle_cnt,
   output logic             gap_err,
   output logic             gap_err_flag,
   output logic [15:0]      b_len,
   output logic             b_len_vld
);

   // state   | meaning
   // EMPTY   | no bottle, waiting for sensor high
   // RISE    | sensor high, qualifying leading edge
   // PRESENT | bottle accepted as present
   // FALL    | sensor low, qualifying trailing edge
   typedef enum logic [1:0] {ST_EMPTY, ST_RISE, ST_PRESENT, ST_FALL} state_t;

   localparam logic [15:0] DEB_LAST  = 16'(DEB_CYC - 1);
   localparam logic [15:0] MIN_GAP_V = 16'(MIN_GAP);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [15:0]            dc_q, dc_d;
   logic [15:0]            gap_q;
   logic                   accept_pt, fall_done, take, reject;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_100) begin
      if (!nRST) begin
         sync_q  <= '0;
         state_q <= ST_EMPTY;
         dc_q    <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], sensor_in};
         state_q <= state_d;
         dc_q    <= dc_d;
      end
   end

   // dc >= DEB_LAST (not ==) lets DEB_CYC=1 resolve on the first RISE/FALL cycle
   always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      case (state_q)
         ST_EMPTY: begin
            if (s) begin
               state_d = ST_RISE;
               dc_d    = 16'd1;
            end
         end
         ST_RISE: begin
            if (!s)                  state_d = ST_EMPTY;
            else if (dc_q >= DEB_LAST) state_d = ST_PRESENT;
            else                     dc_d = dc_q + 16'd1;
         end
         ST_PRESENT: begin
            if (!s) begin
               state_d = ST_FALL;
               dc_d    = 16'd1;
            end
         end
         ST_FALL: begin
            if (s)                   state_d = ST_PRESENT;
            else if (dc_q >= DEB_LAST) state_d = ST_EMPTY;
            else                     dc_d = dc_q + 16'd1;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      accept_pt      = (state_q == ST_RISE) && s && (dc_q >= DEB_LAST);
      fall_done      = (state_q == ST_FALL) && !s && (dc_q >= DEB_LAST);
      bottle_present = (state_q == ST_PRESENT) || (state_q == ST_FALL);
      take           = accept_pt && sense_en && (gap_q >= MIN_GAP_V);
      reject         = accept_pt && sense_en && (gap_q < MIN_GAP_V);
   end

   // clear-then-count on bottle_cnt; set wins over clear on gap_err_flag
   always_ff @(posedge clk_100) begin
      if (!nRST) begin
         gap_q         <= MIN_GAP_V;
         valid_edge_f1 <= 1'b0;
         gap_err       <= 1'b0;
         gap_err_flag  <= 1'b0;
         bottle_cnt    <= '0;
      end else begin
         valid_edge_f1 <= take;
         gap_err       <= reject;
         gap_err_flag  <= reject | (gap_err_flag & ~b_p_clr);
         bottle_cnt    <= (b_p_clr ? '0 : bottle_cnt) + {{(CNT_W-1){1'b0}}, take};
         if (take)                  gap_q <= '0;
         else if (gap_q < MIN_GAP_V) gap_q <= gap_q + 16'd1;
      end
   end

`ifdef BS_LEN_MEAS_EN
   logic [15:0] len_q;
   logic        issued_q;

   always_ff @(posedge clk_100) begin
      if (!nRST) begin
         len_q     <= '0;
         issued_q  <= 1'b0;
         b_len     <= '0;
         b_len_vld <= 1'b0;
      end else begin
         b_len_vld <= 1'b0;
         // load 1 so the EMPTY cycle that first sees s=1 is part of the length
         if ((state_q == ST_EMPTY) && s) begin
            len_q    <= 16'd1;
            issued_q <= 1'b0;
         end else if ((state_q != ST_EMPTY) && s && (len_q != 16'hFFFF)) begin
            len_q <= len_q + 16'd1;
         end
         if (take) issued_q <= 1'b1;
         if (fall_done && issued_q) begin
            b_len     <= len_q;
            b_len_vld <= 1'b1;
         end
      end
   end
`else
   assign b_len     = '0;
   assign b_len_vld = 1'b0;
`endif

endmodule

// File: tb/tb_vry_bottle_sense.sv
// Bench for vry_bottle_sense: run-length debounce model checked every cycle plus literal pins.
module tb_vry_bottle_sense;
   localparam int DEB = 4;
   localparam int GAP = 50;
   localparam int CW  = 16;
`ifdef BS_LEN_MEAS_EN
   localparam bit LEN_EN = 1'b1;
`else
   localparam bit LEN_EN = 1'b0;
`endif

   logic          clk_100 = 1'b0;
   logic          nRST, sensor_in, sense_en, b_p_clr;
   logic          valid_edge_f1, bottle_present, gap_err, gap_err_flag, b_len_vld;
   logic [CW-1:0] bottle_cnt;
   logic [15:0]   b_len;

   vry_bottle_sense #(.SYNC_STAGES(2), .DEB_CYC(DEB), .MIN_GAP(GAP), .CNT_W(CW)) dut (
      .clk_100(clk_100), .nRST(nRST), .sensor_in(sensor_in), .sense_en(sense_en),
      .b_p_clr(b_p_clr), .valid_edge_f1(valid_edge_f1), .bottle_present(bottle_present),
      .bottle_cnt(bottle_cnt), .gap_err(gap_err), .gap_err_flag(gap_err_flag),
      .b_len(b_len), .b_len_vld(b_len_vld));

   always #5 clk_100 = ~clk_100;

   int cyc = 0;
   always @(posedge clk_100) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // Model: debounced level flips after DEB consecutive synchronised samples disagree with it.
   bit          m_sync0, m_sync1, m_s, m_pres, m_issued, m_accept, m_gone;
   int          m_run, m_gap, m_len;
   bit          m_vef, m_ge, m_gef, m_blv;
   logic [CW-1:0] m_cnt;
   logic [15:0] m_blen;

   always @(posedge clk_100) begin
      if (!nRST) begin
         m_sync0 = 0; m_sync1 = 0; m_pres = 0; m_run = 0; m_gap = GAP;
         m_vef = 0; m_ge = 0; m_gef = 0; m_cnt = '0; m_len = 0; m_blen = '0;
         m_blv = 0; m_issued = 0;
      end else begin
         m_s = m_sync1; m_sync1 = m_sync0; m_sync0 = sensor_in;
         m_vef = 0; m_ge = 0; m_blv = 0; m_accept = 0; m_gone = 0;
         if (m_s != m_pres) m_run++; else m_run = 0;
         if (m_s) begin
            if (!m_pres && m_run == 1) m_len = 1;
            else if (m_len < 65535) m_len++;
         end
         if (m_run == DEB) begin
            if (!m_pres) m_accept = 1; else m_gone = 1;
            m_pres = !m_pres;
            m_run = 0;
         end
         if (m_accept && sense_en) begin
            if (m_gap >= GAP) begin m_vef = 1; m_issued = 1; end
            else m_ge = 1;
         end
         m_gap = m_vef ? 0 : ((m_gap < GAP) ? m_gap + 1 : GAP);
         if (b_p_clr) begin m_cnt = '0; m_gef = 0; end
         if (m_vef) m_cnt = m_cnt + 1'b1;
         if (m_ge) m_gef = 1;
         if (m_gone) begin
            if (m_issued && LEN_EN) begin m_blen = m_len[15:0]; m_blv = 1; end
            m_issued = 0;
         end
      end
   end

   always @(negedge clk_100) begin
      if (cyc >= 1) begin
         n_cmp++;
         if ({valid_edge_f1, bottle_present, gap_err, gap_err_flag, b_len_vld} !==
             {m_vef, m_pres, m_ge, m_gef, m_blv} || bottle_cnt !== m_cnt || b_len !== m_blen) begin
            n_err++;
            $display("FAIL model_cyc%0d: got vef=%b pres=%b cnt=%0d ge=%b gef=%b blen=%0d blv=%b want vef=%b pres=%b cnt=%0d ge=%b gef=%b blen=%0d blv=%b",
                     cyc, valid_edge_f1, bottle_present, bottle_cnt, gap_err, gap_err_flag, b_len, b_len_vld,
                     m_vef, m_pres, m_cnt, m_ge, m_gef, m_blen, m_blv);
         end
      end
   end

   int c_vef, c_ge, c_blv, c_pres, vef_first;
   always @(negedge clk_100) begin
      if (cyc >= 1) begin
         c_vef  += int'(valid_edge_f1);
         c_ge   += int'(gap_err);
         c_blv  += int'(b_len_vld);
         c_pres += int'(bottle_present);
         if (valid_edge_f1 && vef_first < 0) vef_first = cyc;
      end
   end

   task automatic clr_mon();
      c_vef = 0; c_ge = 0; c_blv = 0; c_pres = 0; vef_first = -1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_100);
   endtask

   task automatic bottle(input int hi, input int lo);
      sensor_in = 1'b1; step(hi);
      sensor_in = 1'b0; step(lo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   int r;
   initial begin
      nRST = 1'b0; sensor_in = 1'b0; sense_en = 1'b1; b_p_clr = 1'b0;
      clr_mon();
      @(negedge clk_100);
      for (int i = 0; i < 10; i++) begin
         sensor_in = i[0];
         step(1);
      end
      check("reset_outputs", int'({valid_edge_f1, bottle_present, bottle_cnt, gap_err, gap_err_flag, b_len, b_len_vld}), 0);
      nRST = 1'b1; sensor_in = 1'b0;
      clr_mon();
      step(10);
      check("idle_quiet", c_vef + c_ge + c_blv + c_pres + int'(bottle_cnt), 0);

      // clean 20-cycle bottle
      clr_mon();
      r = cyc;
      bottle(20, 15);
      check("latency", vef_first - r, 6);
      check("vef_pulses_t2", c_vef, 1);
      check("cnt_t2", int'(bottle_cnt), 1);
      check("present_len_t2", c_pres, 20);
      check("blen_t2", int'(b_len), LEN_EN ? 20 : 0);
      check("blv_pulses_t2", c_blv, LEN_EN ? 1 : 0);

      // short pulse then chatter
      step(40);
      clr_mon();
      bottle(3, 2); bottle(2, 2); bottle(2, 10);
      check("chatter_vef", c_vef, 0);
      check("chatter_cnt", int'(bottle_cnt), 1);
      check("chatter_pres", c_pres, 0);

      // minimum gap enforcement
      b_p_clr = 1'b1; step(1); b_p_clr = 1'b0; step(2);
      check("clr_cnt_t4", int'(bottle_cnt), 0);
      clr_mon();
      bottle(10, 20);
      bottle(10, 20);
      check("gap_err_pulses", c_ge, 1);
      check("gap_err_flag_t4", int'(gap_err_flag), 1);
      check("cnt_after_reject", int'(bottle_cnt), 1);
      bottle(10, 30);
      check("cnt_third", int'(bottle_cnt), 2);
      check("vef_pulses_t4", c_vef, 2);
      check("blv_pulses_t4", c_blv, LEN_EN ? 2 : 0);

      // sense_en low across the leading edge
      step(40);
      clr_mon();
      sense_en = 1'b0; sensor_in = 1'b1; step(8);
      sense_en = 1'b1; step(7);
      sensor_in = 1'b0; step(15);
      check("silent_vef", c_vef, 0);
      check("silent_cnt", int'(bottle_cnt), 2);
      check("silent_ge", c_ge, 0);
      bottle(10, 20);
      check("after_silent_cnt", int'(bottle_cnt), 3);
      check("after_silent_vef", c_vef, 1);

      // clear interactions
      step(40);
      b_p_clr = 1'b1; step(1); b_p_clr = 1'b0;
      for (int i = 0; i < 7; i++) bottle(10, 50);
      check("cnt_seven", int'(bottle_cnt), 7);
      sensor_in = 1'b1; step(5);
      b_p_clr = 1'b1; step(1); b_p_clr = 1'b0;
      check("clr_on_accept_vef", int'(valid_edge_f1), 1);
      check("clr_on_accept_cnt", int'(bottle_cnt), 1);
      step(4); sensor_in = 1'b0; step(10);
      sensor_in = 1'b1; step(5);
      b_p_clr = 1'b1; step(1); b_p_clr = 1'b0;
      check("set_wins_ge", int'(gap_err), 1);
      check("set_wins_flag", int'(gap_err_flag), 1);
      check("set_wins_cnt", int'(bottle_cnt), 0);
      step(4); sensor_in = 1'b0; step(15);
      b_p_clr = 1'b1; step(1); b_p_clr = 1'b0;
      check("final_clr_cnt", int'(bottle_cnt), 0);
      check("final_clr_flag", int'(gap_err_flag), 0);

      step(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
